// File: rtl/pipe_adder_pkg.sv
// Shared helpers for pipe_rc_adder: stage-count derivation and slice indexing.
package pipe_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;

   function automatic int calc_stages(input int width, input int chunk);
      return (chunk > 0) ? width / chunk : 0;
   endfunction

   function automatic bit chunk_ok(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && (width % chunk == 0);
   endfunction

   function automatic int slice_lo(input int k, input int chunk);
      return k * chunk;
   endfunction

   function automatic int slice_hi(input int k, input int chunk);
      return k * chunk + chunk - 1;
   endfunction

endpackage

// File: rtl/rc_chunk.sv
// Combinational CHUNK-bit ripple-carry adder made of full-adder cells.
// c_msb_in is the carry entering the top cell, used for signed overflow.
module rc_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co       = c[CHUNK];
   assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry add/subtract, one CHUNK-bit slice per stage, valid/ready
// on both sides. Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_rc_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = calc_stages(WIDTH, CHUNK);
   localparam int LAST   = STAGES - 1;

   if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("pipe_rc_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   logic [STAGES-1:0] v_q, v_d, ld, drain;
   logic [STAGES-1:0] c_q, c_d, c_in, ch_co;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [WIDTH-1:0]  a_in [STAGES];
   logic [WIDTH-1:0]  b_in [STAGES];
   logic [WIDTH-1:0]  s_in [STAGES];
   logic [CHUNK-1:0]  ch_s [STAGES];
`ifdef PIPE_ADDER_OVF_EN
   logic [STAGES-1:0] msb_c;
   logic              ovf_q, ovf_d;
`else
   logic [STAGES-1:0] unused_msb_c;
`endif

   // Stage operands: stage 0 takes the ports, stage k the registers of stage k-1
   always_comb begin
      c_in    = '0;
      a_in[0] = a;
      b_in[0] = b ^ {WIDTH{sub}};
      s_in[0] = '0;
      c_in[0] = cin ^ sub;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         s_in[k] = s_q[k-1];
         c_in[k] = c_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      rc_chunk #(.CHUNK(CHUNK)) u_chunk (
         .x        (a_in[k][slice_hi(k, CHUNK):slice_lo(k, CHUNK)]),
         .y        (b_in[k][slice_hi(k, CHUNK):slice_lo(k, CHUNK)]),
         .ci       (c_in[k]),
         .s        (ch_s[k]),
         .co       (ch_co[k]),
`ifdef PIPE_ADDER_OVF_EN
         .c_msb_in (msb_c[k])
`else
         .c_msb_in (unused_msb_c[k])
`endif
      );
   end

   // A stage drains when its successor loads, so bubbles collapse from the output back
   always_comb begin
      ld    = '0;
      drain = '0;
      v_d   = '0;
      for (int k = LAST; k >= 0; k--) begin
         if (k == LAST) drain[k] = v_q[k] & out_ready;
         else           drain[k] = ld[k+1];
         if (k == 0) ld[k] = in_valid  & (!v_q[k] | drain[k]);
         else        ld[k] = v_q[k-1] & (!v_q[k] | drain[k]);
         v_d[k] = ld[k] | (v_q[k] & !drain[k]);
      end
   end

   always_comb begin
      c_d = c_q;
      for (int k = 0; k < STAGES; k++) begin
         a_d[k] = a_q[k];
         b_d[k] = b_q[k];
         s_d[k] = s_q[k];
         if (ld[k]) begin
            a_d[k] = a_in[k];
            b_d[k] = b_in[k];
            s_d[k] = s_in[k];
            s_d[k][slice_lo(k, CHUNK) +: CHUNK] = ch_s[k];
            c_d[k] = ch_co[k];
         end
      end
`ifdef PIPE_ADDER_OVF_EN
      ovf_d = ovf_q;
      for (int k = 0; k < STAGES; k++) begin
         if (k == LAST && ld[k]) ovf_d = msb_c[k] ^ ch_co[k];
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         c_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         c_q <= c_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
      end
   end

`ifdef PIPE_ADDER_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`endif

   assign in_ready  = !v_q[0] | drain[0];
   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign cout      = c_q[LAST];

endmodule

// File: tb/tb_pipe_rc_adder.sv
// Self-checking bench for pipe_rc_adder (8-bit/4-bit main instance plus 32-bit
// CHUNK sweep). Define PIPE_ADDER_OVF_EN to also check ovf.
module tb_pipe_rc_adder;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, sum;
   logic       cin, sub, cout;
`ifdef PIPE_ADDER_OVF_EN
   logic       ovf;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t cur_exp;
   logic in_x, out_x;
   logic prev_hold;
   logic [7:0] prev_sum;
   logic prev_cout;

   always #5 clk = ~clk;

   pipe_rc_adder #(.WIDTH(8), .CHUNK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
      , .ovf(ovf)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: integer arithmetic on the operand values, signed range for ovf
   function automatic exp_t model(input logic [7:0] xa, input logic [7:0] xb,
                                  input logic ci, input logic s);
      exp_t e;
      int   r, rs;
      r  = s ? int'(xa) - int'(xb) - int'(ci) : int'(xa) + int'(xb) + int'(ci);
      rs = s ? int'($signed(xa)) - int'($signed(xb)) - int'(ci)
             : int'($signed(xa)) + int'($signed(xb)) + int'(ci);
      e.sum  = 8'(r);
      e.cout = s ? (r >= 0) : (r > 255);
      e.ovf  = (rs > 127) || (rs < -128);
      return e;
   endfunction

   // Called at a falling edge with inputs already set; ends at the next falling edge
   task automatic tick();
      exp_t got;
      #1;
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      chk("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      if (prev_hold) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_sum", sum, prev_sum);
         chk("hold_cout", cout, prev_cout);
      end
      if (out_valid && sb.size() == 0) chk("spurious_out", out_valid, 0);
      if (out_x && sb.size() != 0) begin
         got = sb.pop_front();
         chk("sum", sum, got.sum);
         chk("cout", cout, got.cout);
`ifdef PIPE_ADDER_OVF_EN
         chk("ovf", ovf, got.ovf);
`endif
      end
      if (in_x) sb.push_back(cur_exp);
      prev_hold = out_valid && !out_ready;
      prev_sum  = sum;
      prev_cout = cout;
      @(negedge clk);
   endtask

   task automatic drain_all();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic rand_ops();
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      cur_exp = model(a, b, cin, sub);
   endtask

   // 32-bit sweep over CHUNK = 32 / 8 / 1
   logic        sw_valid = 1'b0;
   logic [31:0] sw_a = '0, sw_b = '0;
   logic        sw_cin = 1'b0, sw_sub = 1'b0;
   int          cyc = 0;
   event        sw_ev;

   function automatic logic [33:0] sw_model(input logic [31:0] xa, input logic [31:0] xb,
                                            input logic ci, input logic s);
      longint r, rs;
      logic [33:0] e;
      r  = s ? longint'(xa) - longint'(xb) - longint'(ci) : longint'(xa) + longint'(xb) + longint'(ci);
      rs = s ? longint'($signed(xa)) - longint'($signed(xb)) - longint'(ci)
             : longint'($signed(xa)) + longint'($signed(xb)) + longint'(ci);
      e[31:0] = 32'(r);
      e[32]   = s ? (r >= 0) : (r > 64'sd4294967295);
      e[33]   = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
      return e;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int CH  = (g == 0) ? 32 : ((g == 1) ? 8 : 1);
      localparam int LAT = 32 / CH;
      logic        ir, ov, co;
      logic [31:0] sm;
      logic [33:0] eq[$];
      int          tq[$];
      logic [33:0] e;
      int          t;
`ifdef PIPE_ADDER_OVF_EN
      logic        of;
`endif
      pipe_rc_adder #(.WIDTH(32), .CHUNK(CH)) u_sw (
         .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir),
         .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(ov),
         .out_ready(1'b1), .sum(sm), .cout(co)
`ifdef PIPE_ADDER_OVF_EN
         , .ovf(of)
`endif
      );
      always @(sw_ev) begin
         if (ov && eq.size() == 0) chk($sformatf("sweep%0d_spurious", CH), ov, 0);
         if (ov && eq.size() != 0) begin
            e = eq.pop_front();
            t = tq.pop_front();
            chk($sformatf("sweep%0d_result", CH), {co, sm}, e[32:0]);
            chk($sformatf("sweep%0d_latency", CH), cyc - t, LAT);
`ifdef PIPE_ADDER_OVF_EN
            chk($sformatf("sweep%0d_ovf", CH), of, e[33]);
`endif
         end
         if (sw_valid && ir) begin
            eq.push_back(sw_model(sw_a, sw_b, sw_cin, sw_sub));
            tq.push_back(cyc);
         end
      end
   end

   vec_t tbl[8];

   initial begin
      int n, sent, outs, first, last, gaps, ins;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      in_x = 1'b0; out_x = 1'b0; prev_hold = 1'b0; prev_sum = '0; prev_cout = 1'b0;
      cur_exp = '{8'h00, 1'b0, 1'b0};

      tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0}};
      tbl[1] = '{8'h05, 8'h07, 1'b0, 1'b1, '{8'hFE, 1'b0, 1'b0}};
      tbl[2] = '{8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b1}};
      tbl[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}};
      tbl[4] = '{8'h00, 8'h00, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b0}};
      tbl[5] = '{8'h10, 8'h20, 1'b1, 1'b0, '{8'h31, 1'b0, 1'b0}};
      tbl[6] = '{8'h05, 8'h02, 1'b1, 1'b1, '{8'h02, 1'b1, 1'b0}};
      tbl[7] = '{8'h0F, 8'h01, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b0}};

      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
`ifdef PIPE_ADDER_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // Directed vectors, one at a time, latency 2
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
         cur_exp = tbl[i].e;
         in_valid = 1'b1;
         tick();
         chk("vec_accept", in_x, 1);
         in_valid = 1'b0;
         n = 1;
         while (!out_valid && n < 10) begin
            tick();
            n++;
         end
         chk($sformatf("vec%0d_latency", i), n, 2);
         tick();
      end
      chk("vec_all_out", sb.size(), 0);

      // Full pipe: blocked input, then simultaneous in/out transfer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rand_ops();
         tick();
      end
      chk("full_occupancy", sb.size(), 2);
      rand_ops();
      tick();
      chk("full_blocked", in_x, 0);
      out_ready = 1'b1;
      tick();
      chk("full_both_in", in_x, 1);
      chk("full_both_out", out_x, 1);
      chk("full_occupancy_kept", sb.size(), 2);
      drain_all();

      // Reset with two results in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rand_ops();
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_in_ready", in_ready, 1);
      sb.delete();
      prev_hold = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (6) tick();

      // Random back-pressure stream
      sent = 0; n = 0; in_x = 1'b0; in_valid = 1'b0;
      while ((sent < 40 || sb.size() != 0) && n < 3000) begin
         if (!in_valid || in_x) begin
            if (sent < 40 && $urandom_range(0, 3) != 0) begin
               in_valid = 1'b1;
               rand_ops();
            end else in_valid = 1'b0;
         end
         out_ready = 1'($urandom);
         tick();
         if (in_x) sent++;
         n++;
      end
      chk("bp_finished", n < 3000, 1);
      in_valid = 1'b0;
      drain_all();

      // Throughput: 100 ops back to back
      out_ready = 1'b1;
      outs = 0; first = -1; last = -1; gaps = 0; ins = 0;
      for (int t = 0; t < 110; t++) begin
         in_valid = (t < 100);
         rand_ops();
         tick();
         if (in_x) ins++;
         if (out_x) begin
            if (outs == 0) first = t;
            else if (t != last + 1) gaps++;
            last = t;
            outs++;
         end
      end
      chk("tp_inputs", ins, 100);
      chk("tp_outputs", outs, 100);
      chk("tp_first", first, 2);
      chk("tp_last", last, 101);
      chk("tp_gaps", gaps, 0);
      in_valid = 1'b0;

      // 32-bit sweep
      for (int i = 0; i < 1040; i++) begin
         sw_valid = (i < 1000);
         sw_a   = $urandom;
         sw_b   = $urandom;
         sw_cin = 1'($urandom);
         sw_sub = 1'($urandom);
         if (i % 50 == 0) begin
            sw_a = 32'hFFFF_FFFF; sw_b = 32'h0000_0001; sw_cin = 1'b0; sw_sub = 1'b0;
         end
         #1 ->sw_ev;
         @(negedge clk);
         cyc++;
      end
      chk("sweep32_drain", g_sw[0].eq.size(), 0);
      chk("sweep8_drain", g_sw[1].eq.size(), 0);
      chk("sweep1_drain", g_sw[2].eq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
